mc_controller: RTL and testbench
================================

# mc_controller

Multi-cycle control unit for the RV32I core. Owns the instruction-sequencing FSM and the ALU-operation decoder, and drives every datapath strobe and mux select around the shared 32-bit ALU, register file, PC, IR and unified memory port. Sits between the instruction register and the datapath. The only ALU flag it consumes is `zero`.

## Interface
Parameters: none.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `instr` in 32: IR contents; valid from DECODE onward.
- `zero` in 1: ALU zero flag, combinational from the current `aluc` and operands.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access request; held until `mem_ready`.
- `mem_write` out 1: the access is a store.
- `adr_src` out 1: memory address select; 0 = PC, 1 = ALU-out register.
- `ir_write` out 1: load IR (and old-PC) from read data.
- `pc_write` out 1: load PC from the result mux.
- `reg_write` out 1: register-file write enable.
- `result_src` out 2: 00 = ALU-out register, 01 = read data, 10 = ALU result.
- `alu_src_a` out 2: 00 = PC, 01 = old PC, 10 = rs1, 11 = constant 0.
- `alu_src_b` out 2: 00 = rs2, 01 = immediate, 10 = constant 4.
- `imm_src` out 3: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- `aluc` out 4: ALU operation code.
- `illegal` out 1: sticky illegal-instruction flag.

## Operation
ALU codes:
- 0000 add, 0001 sub, 0010 and, 0011 or, 0100 sra.
- 0101 slt, 0110 srl, 0111 sll, 1000 sltu, 1001 xor.

States, with the actions taken in each:
- FETCH: `mem_req`=1, `adr_src`=0, ALU computes PC+4 (a=00, b=10, add), `result_src`=10.
  - On `mem_ready`: `ir_write`=1, `pc_write`=1, go to DECODE. Otherwise stay.
- DECODE: ALU computes old PC + B-immediate (a=01, b=01, imm 010, add); the result latches into ALU-out. Dispatch on opcode:
  - 0000011 / 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 0010111 → AUIPC
  - anything else → ILLEGAL. Invalid funct3/funct7 (listed below) also go to ILLEGAL.
- MEMADR: rs1 + imm (imm I for loads, S for stores), add → MEMREAD (load) or MEMWRITE (store).
- MEMREAD: `mem_req`=1, `adr_src`=1; wait for `mem_ready` → MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1 → FETCH.
- MEMWRITE: `mem_req`=1, `mem_write`=1, `adr_src`=1; wait for `mem_ready` → FETCH.
- EXECR: rs1 op rs2 → ALUWB.
- EXECI: rs1 op imm I → ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1 → FETCH.
- BRANCH: rs1 vs rs2 with `aluc` chosen by funct3; `result_src`=00; `pc_write`=taken → FETCH.
  - 000 beq: sub, taken if zero=1
  - 001 bne: sub, taken if zero=0
  - 100 blt: slt, taken if zero=0
  - 101 bge: slt, taken if zero=1
  - 110 bltu: sltu, taken if zero=0
  - 111 bgeu: sltu, taken if zero=1
  - 010 and 011 are illegal.
- JAL: `pc_write`=1 with `result_src`=00 (target computed in DECODE); ALU computes old PC+4 (a=01, b=10) → ALUWB.
- JALR: rs1 + imm I, add → JALRPC.
- JALRPC: `pc_write`=1, `result_src`=00; ALU computes old PC+4 → ALUWB. The target's bit 0 is not cleared here; the datapath clears it.
- LUI: 0 + imm U (a=11) → ALUWB.
- AUIPC: old PC + imm U → ALUWB.
- ILLEGAL: `illegal`=1. Terminal state: no strobes, no `mem_req`. Left only by reset.

ALU decode by funct3 (R-type and I-type), with the R-type funct7 rule:
- 000: add, or sub when R-type funct7=0100000. I-type is always add.
- 001: sll. 010: slt. 011: sltu. 100: xor.
- 101: srl, or sra when bit 30 is set. The bit-30 rule applies to both R-type and I-type.
- 110: or. 111: and.
- R-type funct7 must be 0000000, or 0100000 only with funct3 000/101; otherwise ILLEGAL.

## Timing
- Next state is registered. All outputs are combinational from the state register, `instr`, `zero` and `mem_ready`.
- While `rst_n`=0: next state = FETCH and `illegal` clears. All strobes (`mem_req`, `mem_write`, `ir_write`, `pc_write`, `reg_write`) are forced to 0 and all selects to 0.
  - FETCH issues `mem_req` in the first cycle with `rst_n`=1.
- Reset asserted mid-instruction (including while waiting on `mem_ready`) aborts the instruction. No write strobe is asserted in that cycle.
- Cycle counts with zero-wait memory:
  - branch: 3
  - R / I / LUI / AUIPC / JAL / store: 4
  - load / JALR: 5
- Each memory wait cycle adds 1. `mem_req` stays high and all selects stay stable while waiting.
- `mem_ready` is ignored in every state that does not assert `mem_req`.
- `instr` is not decoded in FETCH, where it is stale.

## Structure
- Package `ctrl_pkg` holds:
  - the state enum
  - the `aluc` code constants, shared with the ALU
  - opcode constants
  - mux-select constants for `result_src`, `alu_src_a`, `alu_src_b` and `imm_src`.
- One combinational sub-module, `alu_decoder`: inputs (op class, funct3, funct7[5], illegal-funct) → outputs (`aluc`, `funct_illegal`).

## Test plan
- add x3,x1,x2 (0x002081B3), `mem_ready` always 1 → states FETCH, DECODE, EXECR, ALUWB; `aluc`=0000 in EXECR; `reg_write` only in ALUWB; back in FETCH on cycle 5.
- sub / sra / srai / sltu → `aluc` 0001 / 0100 / 0100 / 1000 in EXEC.
- lw with `mem_ready` held low 3 cycles in MEMREAD → `mem_req` and `adr_src`=1 held for 4 cycles; MEMWB follows the ready cycle; total 8 cycles.
- beq with zero=1 → `pc_write`=1 in BRANCH; with zero=0 → `pc_write`=0. bge with zero=1 → taken.
- jal → `pc_write` in JAL, `reg_write` in ALUWB with `alu_src_a`=01 and `alu_src_b`=10 in the JAL cycle. jalr → states JALR, JALRPC, ALUWB.
- Illegal opcode 0x0000007F, and R-type with funct7=0000001 → ILLEGAL; `illegal` stays 1 with all strobes 0 for 10 cycles. Reset pulse mid-MEMWRITE → `mem_write` drops that cycle, then FETCH.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I controller: FSM states, ALU codes,
// opcodes and datapath mux-select encodings.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALRPC   = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14,
        S_ILLEGAL  = 4'd15
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SRA  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_XOR  = 4'b1001;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Operation class handed to the ALU decoder
    localparam logic [1:0] OPC_ADD = 2'b00;
    localparam logic [1:0] OPC_R   = 2'b01;
    localparam logic [1:0] OPC_I   = 2'b10;
    localparam logic [1:0] OPC_BR  = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Equality branches take on zero, compare branches on the slt result; funct3[0] inverts.
    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
        return zero ^ funct3[0] ^ funct3[2];
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU-operation decoder: maps op class and funct fields to an ALU code
// and flags funct encodings that have no legal meaning.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [1:0] op_class_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_b5_i,
    input  logic       funct7_rsvd_i,
    output logic [3:0] aluc_o,
    output logic       funct_illegal_o
);

    // ALU code and funct legality per op class
    always_comb begin
        aluc_o          = ALU_ADD;
        funct_illegal_o = 1'b0;
        case (op_class_i)
            OPC_R, OPC_I: begin
                case (funct3_i)
                    3'b000:  aluc_o = ((op_class_i == OPC_R) && funct7_b5_i) ? ALU_SUB : ALU_ADD;
                    3'b001:  aluc_o = ALU_SLL;
                    3'b010:  aluc_o = ALU_SLT;
                    3'b011:  aluc_o = ALU_SLTU;
                    3'b100:  aluc_o = ALU_XOR;
                    3'b101:  aluc_o = funct7_b5_i ? ALU_SRA : ALU_SRL;
                    3'b110:  aluc_o = ALU_OR;
                    3'b111:  aluc_o = ALU_AND;
                    default: aluc_o = ALU_ADD;
                endcase
                if (op_class_i == OPC_R) begin
                    funct_illegal_o = funct7_rsvd_i |
                                      (funct7_b5_i & (funct3_i != 3'b000) & (funct3_i != 3'b101));
                end else begin
                    funct_illegal_o = 1'b0;
                end
            end
            OPC_BR: begin
                case (funct3_i[2:1])
                    2'b00:   aluc_o = ALU_SUB;
                    2'b10:   aluc_o = ALU_SLT;
                    2'b11:   aluc_o = ALU_SLTU;
                    default: begin
                        aluc_o          = ALU_SUB;
                        funct_illegal_o = 1'b1;
                    end
                endcase
            end
            default: begin
                aluc_o          = ALU_ADD;
                funct_illegal_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle RV32I control unit: instruction-sequencing FSM driving every datapath
// strobe and mux select; outputs are decoded from the state register and live inputs.
module mc_controller
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_write,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  imm_src,
    output logic [3:0]  aluc,
    output logic        illegal
);

    state_t      state_q;
    state_t      state_d;
    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [1:0]  op_class_s;
    logic [3:0]  aluc_dec_s;
    logic        funct_illegal_s;
    logic        unused_instr_s;

    assign opcode_s       = instr[6:0];
    assign funct3_s       = instr[14:12];
    assign unused_instr_s = ^{instr[24:15], instr[11:7]};

    // Op class for the ALU decoder, derived from the opcode
    always_comb begin
        case (opcode_s)
            OP_RTYPE:  op_class_s = OPC_R;
            OP_ITYPE:  op_class_s = OPC_I;
            OP_BRANCH: op_class_s = OPC_BR;
            default:   op_class_s = OPC_ADD;
        endcase
    end

    alu_decoder u_alu_decoder (
        .op_class_i      (op_class_s),
        .funct3_i        (funct3_s),
        .funct7_b5_i     (instr[30]),
        .funct7_rsvd_i   (|{instr[31], instr[29:25]}),
        .aluc_o          (aluc_dec_s),
        .funct_illegal_o (funct_illegal_s)
    );

    // Next-state and output decode; reset forces every strobe and select low
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        imm_src    = IMM_I;
        aluc       = ALU_ADD;
        illegal    = 1'b0;
        if (!rst_n) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALU;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                    state_d    = mem_ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    imm_src   = IMM_B;
                    case (opcode_s)
                        OP_LOAD, OP_STORE: state_d = S_MEMADR;
                        OP_RTYPE:          state_d = funct_illegal_s ? S_ILLEGAL : S_EXECR;
                        OP_ITYPE:          state_d = S_EXECI;
                        OP_BRANCH:         state_d = funct_illegal_s ? S_ILLEGAL : S_BRANCH;
                        OP_JAL:            state_d = S_JAL;
                        OP_JALR:           state_d = S_JALR;
                        OP_LUI:            state_d = S_LUI;
                        OP_AUIPC:          state_d = S_AUIPC;
                        default:           state_d = S_ILLEGAL;
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    if (opcode_s == OP_STORE) begin
                        imm_src = IMM_S;
                        state_d = S_MEMWRITE;
                    end else begin
                        imm_src = IMM_I;
                        state_d = S_MEMREAD;
                    end
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    state_d = mem_ready ? S_MEMWB : S_MEMREAD;
                end
                S_MEMWB: begin
                    result_src = RES_RDATA;
                    reg_write  = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEMWRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                    state_d   = mem_ready ? S_FETCH : S_MEMWRITE;
                end
                S_EXECR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_RS2;
                    aluc      = aluc_dec_s;
                    state_d   = S_ALUWB;
                end
                S_EXECI: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    imm_src   = IMM_I;
                    aluc      = aluc_dec_s;
                    state_d   = S_ALUWB;
                end
                S_ALUWB: begin
                    result_src = RES_ALUOUT;
                    reg_write  = 1'b1;
                    state_d    = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_RS2;
                    aluc       = aluc_dec_s;
                    result_src = RES_ALUOUT;
                    pc_write   = branch_taken(funct3_s, zero);
                    state_d    = S_FETCH;
                end
                // Target already sits in ALU-out; the ALU now forms the link value
                S_JAL, S_JALRPC: begin
                    pc_write   = 1'b1;
                    result_src = RES_ALUOUT;
                    alu_src_a  = SRCA_OLDPC;
                    alu_src_b  = SRCB_FOUR;
                    imm_src    = IMM_J;
                    state_d    = S_ALUWB;
                end
                S_JALR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    imm_src   = IMM_I;
                    state_d   = S_JALRPC;
                end
                S_LUI: begin
                    alu_src_a = SRCA_ZERO;
                    alu_src_b = SRCB_IMM;
                    imm_src   = IMM_U;
                    state_d   = S_ALUWB;
                end
                S_AUIPC: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    imm_src   = IMM_U;
                    state_d   = S_ALUWB;
                end
                S_ILLEGAL: begin
                    illegal = 1'b1;
                    state_d = S_ILLEGAL;
                end
                default: begin
                    state_d = S_ILLEGAL;
                end
            endcase
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed, table-driven bench for mc_controller: per-cycle expected outputs taken
// from the state action table, with don't-care selects masked out.
module tb_mc_controller;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] imm_src;
        logic [3:0] aluc;
        logic       illegal;
    } outs_t;

    typedef struct packed {
        outs_t o;
        logic  alu_c;
        logic  res_c;
        logic  all_c;
    } exp_t;

    typedef struct {
        logic        rst_n;
        logic [31:0] instr;
        logic        zero;
        logic        rdy;
        exp_t        e;
        string       name;
    } vec_t;

    localparam logic [31:0] STALE = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
    logic [1:0]  result_src, alu_src_a, alu_src_b;
    logic [2:0]  imm_src;
    logic [3:0]  aluc;
    logic [19:0] act_s;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vq[$];

    mc_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .imm_src    (imm_src),
        .aluc       (aluc),
        .illegal    (illegal)
    );

    assign act_s = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                    result_src, alu_src_a, alu_src_b, imm_src, aluc, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t ob(input logic [5:0] stb, input logic [1:0] res, input logic [1:0] a,
                                 input logic [1:0] b, input logic [2:0] imm, input logic [3:0] alu,
                                 input logic ill);
        outs_t o;
        o = {stb, res, a, b, imm, alu, ill};
        return o;
    endfunction

    function automatic exp_t mk(input outs_t o, input logic alu_c, input logic res_c, input logic all_c);
        exp_t e;
        e.o     = o;
        e.alu_c = alu_c;
        e.res_c = res_c;
        e.all_c = all_c;
        return e;
    endfunction

    // Strobe order: {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write}
    function automatic exp_t e_reset();
        return mk(ob(6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0), 1'b0, 1'b0, 1'b1);
    endfunction
    function automatic exp_t e_fetch(input logic r);
        return mk(ob({3'b100, r, r, 1'b0}, 2'b10, 2'b00, 2'b10, 3'b000, 4'b0000, 1'b0), 1'b1, 1'b1, 1'b0);
    endfunction
    function automatic exp_t e_decode();
        return mk(ob(6'b000000, 2'b00, 2'b01, 2'b01, 3'b010, 4'b0000, 1'b0), 1'b1, 1'b0, 1'b0);
    endfunction
    function automatic exp_t e_memadr(input logic st);
        return mk(ob(6'b000000, 2'b00, 2'b10, 2'b01, {2'b00, st}, 4'b0000, 1'b0), 1'b1, 1'b0, 1'b0);
    endfunction
    function automatic exp_t e_memread();
        return mk(ob(6'b101000, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0), 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic exp_t e_memwb();
        return mk(ob(6'b000001, 2'b01, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0), 1'b0, 1'b1, 1'b0);
    endfunction
    function automatic exp_t e_memwrite();
        return mk(ob(6'b111000, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0), 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic exp_t e_execr(input logic [3:0] c);
        return mk(ob(6'b000000, 2'b00, 2'b10, 2'b00, 3'b000, c, 1'b0), 1'b1, 1'b0, 1'b0);
    endfunction
    function automatic exp_t e_execi(input logic [3:0] c);
        return mk(ob(6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, c, 1'b0), 1'b1, 1'b0, 1'b0);
    endfunction
    function automatic exp_t e_aluwb();
        return mk(ob(6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0), 1'b0, 1'b1, 1'b0);
    endfunction
    function automatic exp_t e_branch(input logic [3:0] c, input logic t);
        return mk(ob({4'b0000, t, 1'b0}, 2'b00, 2'b10, 2'b00, 3'b000, c, 1'b0), 1'b1, 1'b1, 1'b0);
    endfunction
    function automatic exp_t e_jal();
        return mk(ob(6'b000010, 2'b00, 2'b01, 2'b10, 3'b000, 4'b0000, 1'b0), 1'b1, 1'b1, 1'b0);
    endfunction
    function automatic exp_t e_jalr();
        return mk(ob(6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 4'b0000, 1'b0), 1'b1, 1'b0, 1'b0);
    endfunction
    function automatic exp_t e_upper(input logic [1:0] a);
        return mk(ob(6'b000000, 2'b00, a, 2'b01, 3'b100, 4'b0000, 1'b0), 1'b1, 1'b0, 1'b0);
    endfunction
    function automatic exp_t e_illegal();
        return mk(ob(6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b1), 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic logic [19:0] mask_of(input exp_t e);
        outs_t m;
        m            = '0;
        m.mem_req    = 1'b1;
        m.mem_write  = 1'b1;
        m.ir_write   = 1'b1;
        m.pc_write   = 1'b1;
        m.reg_write  = 1'b1;
        m.illegal    = 1'b1;
        m.adr_src    = e.all_c | e.o.mem_req;
        m.result_src = {2{e.all_c | e.res_c}};
        m.alu_src_a  = {2{e.all_c | e.alu_c}};
        m.alu_src_b  = {2{e.all_c | e.alu_c}};
        m.aluc       = {4{e.all_c | e.alu_c}};
        m.imm_src    = {3{e.all_c | (e.alu_c & (e.o.alu_src_b == 2'b01))}};
        return m;
    endfunction

    function automatic void push(input logic rn, input logic [31:0] ins, input logic z,
                                 input logic r, input exp_t e, input string nm);
        vec_t v;
        v.rst_n = rn;
        v.instr = ins;
        v.zero  = z;
        v.rdy   = r;
        v.e     = e;
        v.name  = nm;
        vq.push_back(v);
    endfunction

    function automatic void push_r(input logic [31:0] ins, input logic [3:0] c, input string nm);
        push(1'b1, STALE, 1'b0, 1'b1, e_fetch(1'b1), {nm, "_fetch"});
        push(1'b1, ins, 1'b0, 1'b0, e_decode(), {nm, "_decode"});
        push(1'b1, ins, 1'b1, 1'b1, e_execr(c), {nm, "_exec"});
        push(1'b1, ins, 1'b0, 1'b1, e_aluwb(), {nm, "_aluwb"});
    endfunction

    function automatic void push_i(input logic [31:0] ins, input logic [3:0] c, input string nm);
        push(1'b1, STALE, 1'b0, 1'b1, e_fetch(1'b1), {nm, "_fetch"});
        push(1'b1, ins, 1'b0, 1'b1, e_decode(), {nm, "_decode"});
        push(1'b1, ins, 1'b0, 1'b0, e_execi(c), {nm, "_exec"});
        push(1'b1, ins, 1'b0, 1'b1, e_aluwb(), {nm, "_aluwb"});
    endfunction

    function automatic void push_br(input logic [31:0] ins, input logic z, input logic [3:0] c,
                                    input logic t, input string nm);
        push(1'b1, STALE, 1'b0, 1'b1, e_fetch(1'b1), {nm, "_fetch"});
        push(1'b1, ins, 1'b0, 1'b1, e_decode(), {nm, "_decode"});
        push(1'b1, ins, z, 1'b1, e_branch(c, t), {nm, "_branch"});
    endfunction

    task automatic run_vec(input vec_t v);
        logic [19:0] m, got, want;
        @(negedge clk);
        rst_n     = v.rst_n;
        instr     = v.instr;
        zero      = v.zero;
        mem_ready = v.rdy;
        #1;
        m    = mask_of(v.e);
        got  = act_s & m;
        want = v.e.o;
        want = want & m;
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %05h required %05h (raw %05h)", v.name, got, want, act_s);
        end
    endtask

    task automatic step(input logic rn, input logic [31:0] ins, input logic z, input logic r,
                        input exp_t e, input string nm);
        vec_t v;
        v.rst_n = rn;
        v.instr = ins;
        v.zero  = z;
        v.rdy   = r;
        v.e     = e;
        v.name  = nm;
        run_vec(v);
    endtask

    task automatic illegal_seq(input logic [31:0] ins, input string nm);
        step(1'b1, STALE, 1'b0, 1'b1, e_fetch(1'b1), {nm, "_fetch"});
        step(1'b1, ins, 1'b0, 1'b1, e_decode(), {nm, "_decode"});
        for (int k = 0; k < 10; k++) begin
            step(1'b1, ins, k[0], 1'b1, e_illegal(), $sformatf("%s_hold%0d", nm, k));
        end
        step(1'b0, ins, 1'b0, 1'b1, e_reset(), {nm, "_reset"});
    endtask

    initial begin
        rst_n     = 1'b0;
        instr     = STALE;
        zero      = 1'b0;
        mem_ready = 1'b0;

        push(1'b0, STALE, 1'b0, 1'b1, e_reset(), "reset0");
        push(1'b0, STALE, 1'b1, 1'b1, e_reset(), "reset1");
        push_r(32'h0020_81B3, 4'b0000, "add");
        push(1'b1, STALE, 1'b0, 1'b0, e_fetch(1'b0), "sub_fetch_wait");
        push_r(32'h4020_81B3, 4'b0001, "sub");
        push_r(32'h4020_D1B3, 4'b0100, "sra");
        push_r(32'h0020_B1B3, 4'b1000, "sltu");
        push_r(32'h0020_C1B3, 4'b1001, "xor");
        push_i(32'h4030_D193, 4'b0100, "srai");
        push_i(32'h0030_D193, 4'b0110, "srli");
        push_i(32'h4000_8193, 4'b0000, "addi_b30");
        push_i(32'h0FF0_F193, 4'b0010, "andi");
        push_i(32'h0030_9193, 4'b0111, "slli");
        // lw with three wait cycles in MEMREAD: eight cycles in total
        push(1'b1, STALE, 1'b0, 1'b1, e_fetch(1'b1), "lw_fetch");
        push(1'b1, 32'h0000_A183, 1'b0, 1'b1, e_decode(), "lw_decode");
        push(1'b1, 32'h0000_A183, 1'b0, 1'b1, e_memadr(1'b0), "lw_memadr");
        push(1'b1, 32'h0000_A183, 1'b0, 1'b0, e_memread(), "lw_wait0");
        push(1'b1, 32'h0000_A183, 1'b0, 1'b0, e_memread(), "lw_wait1");
        push(1'b1, 32'h0000_A183, 1'b0, 1'b0, e_memread(), "lw_wait2");
        push(1'b1, 32'h0000_A183, 1'b0, 1'b1, e_memread(), "lw_ready");
        push(1'b1, 32'h0000_A183, 1'b0, 1'b1, e_memwb(), "lw_memwb");
        push(1'b1, STALE, 1'b0, 1'b1, e_fetch(1'b1), "sw_fetch");
        push(1'b1, 32'h0030_A023, 1'b0, 1'b1, e_decode(), "sw_decode");
        push(1'b1, 32'h0030_A023, 1'b0, 1'b1, e_memadr(1'b1), "sw_memadr");
        push(1'b1, 32'h0030_A023, 1'b0, 1'b1, e_memwrite(), "sw_memwrite");
        push_br(32'h0020_8063, 1'b1, 4'b0001, 1'b1, "beq_z1");
        push_br(32'h0020_8063, 1'b0, 4'b0001, 1'b0, "beq_z0");
        push_br(32'h0020_9063, 1'b1, 4'b0001, 1'b0, "bne_z1");
        push_br(32'h0020_D063, 1'b1, 4'b0101, 1'b1, "bge_z1");
        push_br(32'h0020_E063, 1'b0, 4'b1000, 1'b1, "bltu_z0");
        push(1'b1, STALE, 1'b0, 1'b1, e_fetch(1'b1), "jal_fetch");
        push(1'b1, 32'h0080_00EF, 1'b0, 1'b1, e_decode(), "jal_decode");
        push(1'b1, 32'h0080_00EF, 1'b0, 1'b0, e_jal(), "jal_jal");
        push(1'b1, 32'h0080_00EF, 1'b0, 1'b1, e_aluwb(), "jal_aluwb");
        push(1'b1, STALE, 1'b0, 1'b1, e_fetch(1'b1), "jalr_fetch");
        push(1'b1, 32'h0000_80E7, 1'b0, 1'b1, e_decode(), "jalr_decode");
        push(1'b1, 32'h0000_80E7, 1'b0, 1'b1, e_jalr(), "jalr_jalr");
        push(1'b1, 32'h0000_80E7, 1'b0, 1'b1, e_jal(), "jalr_jalrpc");
        push(1'b1, 32'h0000_80E7, 1'b0, 1'b1, e_aluwb(), "jalr_aluwb");
        push(1'b1, STALE, 1'b0, 1'b1, e_fetch(1'b1), "lui_fetch");
        push(1'b1, 32'h1234_51B7, 1'b0, 1'b1, e_decode(), "lui_decode");
        push(1'b1, 32'h1234_51B7, 1'b0, 1'b1, e_upper(2'b11), "lui_lui");
        push(1'b1, 32'h1234_51B7, 1'b0, 1'b1, e_aluwb(), "lui_aluwb");
        push(1'b1, STALE, 1'b0, 1'b1, e_fetch(1'b1), "auipc_fetch");
        push(1'b1, 32'h1234_5197, 1'b0, 1'b1, e_decode(), "auipc_decode");
        push(1'b1, 32'h1234_5197, 1'b0, 1'b1, e_upper(2'b01), "auipc_auipc");
        push(1'b1, 32'h1234_5197, 1'b0, 1'b1, e_aluwb(), "auipc_aluwb");

        for (int i = 0; i < vq.size(); i++) begin
            run_vec(vq[i]);
        end

        illegal_seq(32'h0000_007F, "ill_opcode");
        illegal_seq(32'h0220_81B3, "ill_funct7");
        illegal_seq(32'h0020_A063, "ill_br_f3");
        illegal_seq(32'h4020_91B3, "ill_f7_f3");

        // Reset while a store waits on memory: strobes drop at once, then FETCH
        step(1'b1, STALE, 1'b0, 1'b1, e_fetch(1'b1), "rsw_fetch");
        step(1'b1, 32'h0030_A023, 1'b0, 1'b1, e_decode(), "rsw_decode");
        step(1'b1, 32'h0030_A023, 1'b0, 1'b1, e_memadr(1'b1), "rsw_memadr");
        step(1'b1, 32'h0030_A023, 1'b0, 1'b0, e_memwrite(), "rsw_wait");
        step(1'b0, 32'h0030_A023, 1'b0, 1'b0, e_reset(), "rsw_reset");
        step(1'b1, STALE, 1'b0, 1'b0, e_fetch(1'b0), "rsw_refetch");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
